// File: rtl/arith_pkg.sv
// arith_pkg -- shared types and helpers for the basic-arithmetic sequencers.
// rev 1.0
`default_nettype none

package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  // Bit-counter width: enough to index DATA_WIDTH bits, never narrower than 1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage : arith_pkg

`default_nettype wire

// File: rtl/serial_adder_sequencer_if.sv
// serial_adder_sequencer_if -- operand/result handshake bundle for the serial adder.
// rev 1.0
`default_nettype none

interface serial_adder_sequencer_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  start;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  carry_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] sum;
  logic                  carry_out;

  modport master (
    output start, data_a, data_b, carry_in,
    input  ready, busy, done, sum, carry_out
  );

  modport slave (
    input  start, data_a, data_b, carry_in,
    output ready, busy, done, sum, carry_out
  );

endinterface : serial_adder_sequencer_if

`default_nettype wire

// File: rtl/serial_full_adder_cell.sv
// serial_full_adder_cell -- combinational 1-bit full adder from two half-adder stages.
// rev 1.0
`default_nettype none

module serial_full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;

  assign s         = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;

  assign cout      = ha0_carry | ha1_carry;

endmodule : serial_full_adder_cell

`default_nettype wire

// File: rtl/serial_adder_sequencer.sv
// serial_adder_sequencer -- bit-serial DATA_WIDTH adder, LSB first, one bit per clock.
// rev 1.0
`default_nettype none

module serial_adder_sequencer
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_adder_sequencer_if.slave  bus
);

  localparam int unsigned     CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  seq_state_t            state;
  seq_state_t            state_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [DATA_WIDTH-1:0] psum;
  logic [DATA_WIDTH-1:0] psum_nxt;
  logic                  carry;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  carry_out_q;
  logic                  fa_s;
  logic                  fa_c;
  logic                  last_bit;
  logic                  ready;
  logic                  busy;
  logic                  done;

  serial_full_adder_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (bit_cnt == LAST_BIT);

  // New sum bit enters at the MSB so that after DATA_WIDTH shifts bit i sits at index i.
  assign psum_nxt = (psum >> 1) | (DATA_WIDTH'(fa_s) << (DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      psum        <= '0;
      carry       <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.data_a;
            b_sh    <= bus.data_b;
            carry   <= bus.carry_in;
            bit_cnt <= '0;
            psum    <= '0;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          psum    <= psum_nxt;
          carry   <= fa_c;
          bit_cnt <= bit_cnt + CNT_W'(1);
          // Outputs are written only on the final bit, never with a partial result.
          if (last_bit) begin
            sum_q       <= psum_nxt;
            carry_out_q <= fa_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;

endmodule : serial_adder_sequencer

`default_nettype wire

// File: tb/tb_serial_adder_sequencer.sv
// tb_serial_adder_sequencer -- scoreboard bench for the 8-bit and 1-bit serial adder builds.
// rev 1.0
`default_nettype none

module tb_serial_adder_sequencer;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;
  int   cyc;
  int   done_cnt8;
  int   done_cnt1;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  serial_adder_sequencer_if #(.DATA_WIDTH(8)) if8 ();
  serial_adder_sequencer_if #(.DATA_WIDTH(1)) if1 ();

  serial_adder_sequencer #(.DATA_WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  serial_adder_sequencer #(.DATA_WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumers: compare whenever a done pulse is seen.
  always @(negedge clk) begin
    if (if8.done === 1'b1) begin
      done_cnt8++;
      if (q8.size() == 0) chk("dw8_spurious_done", 1, 0);
      else chk("dw8_result", {55'd0, if8.carry_out, if8.sum}, {55'd0, q8.pop_front()});
    end
    if (if1.done === 1'b1) begin
      done_cnt1++;
      if (q1.size() == 0) chk("dw1_spurious_done", 1, 0);
      else chk("dw1_result", {62'd0, if1.carry_out, if1.sum}, {62'd0, q1.pop_front()});
    end
  end

  task automatic wait_ready8();
    for (int i = 0; i < 100; i++) begin
      if (if8.ready === 1'b1) return;
      @(negedge clk);
    end
    chk("dw8_ready_timeout", 0, 1);
  endtask

  task automatic wait_ready1();
    for (int i = 0; i < 100; i++) begin
      if (if1.ready === 1'b1) return;
      @(negedge clk);
    end
    chk("dw1_ready_timeout", 0, 1);
  endtask

  task automatic drain8();
    for (int i = 0; i < 100; i++) begin
      if (q8.size() == 0) break;
      @(negedge clk);
    end
    chk("dw8_drain", q8.size(), 0);
  endtask

  // Returns at the negedge of cycle 1 after the accepting edge.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    wait_ready8();
    if8.start    = 1'b1;
    if8.data_a   = a;
    if8.data_b   = b;
    if8.carry_in = ci;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, ci});
    @(negedge clk);
    if8.start    = 1'b0;
    if8.data_a   = 8'($urandom);
    if8.data_b   = 8'($urandom);
    if8.carry_in = 1'($urandom);
  endtask

  initial begin
    int d0;
    int acc[3];
    logic [7:0] bb_a[3];
    logic [7:0] bb_b[3];
    n_run = 0; n_fail = 0; cyc = 0; done_cnt8 = 0; done_cnt1 = 0;
    if8.start = 0; if8.data_a = 0; if8.data_b = 0; if8.carry_in = 0;
    if1.start = 0; if1.data_a = 0; if1.data_b = 0; if1.carry_in = 0;
    rst_n = 1'b0;
    #12;
    chk("rst_ready", if8.ready, 1);
    chk("rst_busy", if8.busy, 0);
    chk("rst_done", if8.done, 0);
    chk("rst_sum", if8.sum, 0);
    chk("rst_carry", if8.carry_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with cycle-exact busy/done timing.
    drive8(8'h5A, 8'h3C, 1'b0);
    chk("t1_busy_c1", if8.busy, 1);
    chk("t1_done_c1", if8.done, 0);
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("t1_busy_c%0d", k), if8.busy, (k <= 8) ? 1 : 0);
      chk($sformatf("t1_done_c%0d", k), if8.done, (k == 9) ? 1 : 0);
    end
    chk("t1_ready_c10", if8.ready, 1);
    drain8();

    // Carry-out boundaries.
    drive8(8'hFF, 8'h01, 1'b0);
    drain8();
    drive8(8'hFF, 8'h00, 1'b1);
    drain8();

    // Start pulse during SHIFT must be ignored.
    d0 = done_cnt8;
    drive8(8'h01, 8'h02, 1'b0);
    @(negedge clk);
    if8.start = 1'b1; if8.data_a = 8'h11; if8.data_b = 8'h22; if8.carry_in = 1'b0;
    @(negedge clk);
    if8.start = 1'b0;
    drain8();
    repeat (12) @(negedge clk);
    chk("ign_done_pulses", done_cnt8 - d0, 1);
    chk("ign_sum_held", if8.sum, 8'h03);

    // Asynchronous reset in the middle of SHIFT.
    d0 = done_cnt8;
    drive8(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_busy_before", if8.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", if8.sum, 0);
    chk("mid_rst_carry", if8.carry_out, 0);
    chk("mid_rst_ready", if8.ready, 1);
    chk("mid_rst_busy", if8.busy, 0);
    chk("mid_rst_done", if8.done, 0);
    void'(q8.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", done_cnt8 - d0, 0);
    chk("mid_rst_sum_after", if8.sum, 0);

    // Start held high across three back-to-back operations.
    bb_a[0] = 8'h80; bb_b[0] = 8'h80;
    bb_a[1] = 8'h7F; bb_b[1] = 8'h01;
    bb_a[2] = 8'h00; bb_b[2] = 8'h00;
    if8.start = 1'b1;
    for (int op = 0; op < 3; op++) begin
      wait_ready8();
      if8.data_a   = bb_a[op];
      if8.data_b   = bb_b[op];
      if8.carry_in = 1'b0;
      q8.push_back({1'b0, bb_a[op]} + {1'b0, bb_b[op]});
      acc[op] = cyc;
      @(negedge clk);
    end
    if8.start = 1'b0;
    drain8();
    chk("b2b_spacing01", acc[1] - acc[0], 10);
    chk("b2b_spacing12", acc[2] - acc[1], 10);

    // DATA_WIDTH=1 build: full truth table, done two cycles after accept.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      wait_ready1();
      if1.start    = 1'b1;
      if1.data_a   = v[2];
      if1.data_b   = v[1];
      if1.carry_in = v[0];
      q1.push_back({1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]});
      @(negedge clk);
      if1.start = 1'b0;
      chk($sformatf("dw1_busy_c1_%0d", i), if1.busy, 1);
      chk($sformatf("dw1_done_c1_%0d", i), if1.done, 0);
      @(negedge clk);
      chk($sformatf("dw1_done_c2_%0d", i), if1.done, 1);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("dw1_drain", q1.size(), 0);
    chk("dw1_done_count", done_cnt1, 8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_adder_sequencer

`default_nettype wire
